// File: rtl/tone_period_meter.sv
// tone_period_meter
// Measures the half-period of an asynchronous square wave in clk cycles, in the
// same units as tone_generator's tone_switch_period. Both edges of the
// synchronised input are timed. A value is reported only after two consecutive
// intervals agree within TOLERANCE. A long gap with no edge reports silence
// (period = 0).
//
// state         | meaning
// --------------+--------------------------------------------------------------
// ST_SILENT     | no recent edges; interval counter frozen, period = 0
// ST_FIRST_EDGE | one edge seen, timing the first interval
// ST_CANDIDATE  | holding an unconfirmed interval in cand, waiting for a match
// ST_LOCKED     | consecutive intervals agree; period tracks the input

module tone_period_meter #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2,
    parameter int TOLERANCE   = 4,
    parameter int TIMEOUT     = 4000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sq_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             silent
);

    typedef enum logic [1:0] {
        ST_SILENT     = 2'd0,
        ST_FIRST_EDGE = 2'd1,
        ST_CANDIDATE  = 2'd2,
        ST_LOCKED     = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH:0]   TOL_W     = (WIDTH+1)'(TOLERANCE);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       cand_q, cand_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic                   period_valid_q, period_valid_d;
    state_t                 state_q, state_d;

    logic                   sq_s;
    logic                   edge_s;
    logic [WIDTH:0]         diff;
    logic [WIDTH:0]         diff_abs;
    logic                   agree;
    logic                   timeout_hit;

    // Synchroniser shift and edge detection on the synchronised input.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sq_in};
        sq_s   = sync_q[SYNC_STAGES-1];
        prev_d = sq_s;
        edge_s = sq_s ^ prev_q;
    end

    // Interval comparison; cnt saturates so the extra bit only carries the sign.
    always_comb begin
        diff        = {1'b0, cnt_q} - {1'b0, cand_q};
        diff_abs    = diff[WIDTH] ? ({(WIDTH+1){1'b0}} - diff) : diff;
        agree       = (diff_abs <= TOL_W);
        timeout_hit = (cnt_q == TIMEOUT_W);
    end

    // Interval counter: restart at each edge, frozen while silent, saturating otherwise.
    always_comb begin
        if (edge_s) begin
            cnt_d = WIDTH'(1);
        end else if (state_q == ST_SILENT) begin
            cnt_d = cnt_q;
        end else if (timeout_hit) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Lock/qualify next-state logic; an edge takes precedence over the timeout.
    always_comb begin
        state_d        = state_q;
        cand_d         = cand_q;
        period_d       = period_q;
        period_valid_d = 1'b0;

        case (state_q)
            ST_SILENT: begin
                if (edge_s) begin
                    state_d = ST_FIRST_EDGE;
                end
            end
            ST_FIRST_EDGE: begin
                if (edge_s) begin
                    cand_d  = cnt_q;
                    state_d = ST_CANDIDATE;
                end
            end
            ST_CANDIDATE: begin
                if (edge_s) begin
                    if (agree) begin
                        period_d       = cnt_q;
                        period_valid_d = 1'b1;
                        state_d        = ST_LOCKED;
                    end else begin
                        cand_d = cnt_q;
                    end
                end
            end
            ST_LOCKED: begin
                if (edge_s) begin
                    cand_d = cnt_q;
                    if (agree) begin
                        period_d       = cnt_q;
                        period_valid_d = (cnt_q != period_q);
                    end else begin
                        state_d = ST_CANDIDATE;
                    end
                end
            end
            default: begin
                state_d = ST_SILENT;
            end
        endcase

        if ((state_q != ST_SILENT) && !edge_s && timeout_hit) begin
            state_d        = ST_SILENT;
            period_d       = '0;
            cand_d         = '0;
            period_valid_d = (period_q != '0);
        end
    end

    // Synchroniser and previous-sample flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Interval counter and candidate interval registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            cand_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            cand_q <= cand_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SILENT;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered period report and its strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        period       = period_q;
        period_valid = period_valid_q;
        locked       = (state_q == ST_LOCKED);
        silent       = (state_q == ST_SILENT);
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Self-checking bench for tone_period_meter: a table of hand-derived intervals,
// hand-written reset and timeout sequences, and random tone bursts checked
// against an edge-level reference model.
module tb_tone_period_meter;

    localparam int WIDTH       = 24;
    localparam int SYNC_STAGES = 2;
    localparam int TOLERANCE   = 4;
    localparam int TIMEOUT     = 5000;

    typedef struct {
        int n;       // cycles to hold sq_in after this toggle
        int locked;  // expected after the edge from this toggle
        int silent;
        int period;
        int pulses;  // period_valid pulses since the previous check
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             sq_in;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             silent;

    int errors     = 0;
    int checks     = 0;
    int pulse_cnt  = 0;
    int last_check = 0;

    int tones [4] = '{40, 97, 250, 400};

    // reference model: edge-level view of the meter
    bit m_silent;
    bit m_have_ref;
    bit m_locked;
    int m_ref;
    int m_period;

    tone_period_meter #(
        .WIDTH(WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .TOLERANCE(TOLERANCE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sq_in(sq_in),
        .period(period),
        .period_valid(period_valid),
        .locked(locked),
        .silent(silent)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (period_valid === 1'b1) pulse_cnt++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    function automatic vec_t mk(input int n, input int l, input int s, input int p, input int c);
        vec_t v;
        v.n = n; v.locked = l; v.silent = s; v.period = p; v.pulses = c;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_silent   = 1'b1;
        m_have_ref = 1'b0;
        m_locked   = 1'b0;
        m_ref      = 0;
        m_period   = 0;
    endtask

    // gap = cycles since the previous sq_in transition
    task automatic model_edge(input int gap, output int npulse);
        int d;
        npulse = 0;
        if (!m_silent && gap > TIMEOUT) begin
            if (m_period != 0) npulse++;
            m_period   = 0;
            m_silent   = 1'b1;
            m_have_ref = 1'b0;
            m_locked   = 1'b0;
            m_ref      = 0;
        end
        if (m_silent) begin
            m_silent   = 1'b0;
            m_have_ref = 1'b0;
        end else if (!m_have_ref) begin
            m_ref      = gap;
            m_have_ref = 1'b1;
        end else begin
            d = gap - m_ref;
            if (d < 0) d = -d;
            if (!m_locked) begin
                if (d <= TOLERANCE) begin
                    m_locked = 1'b1;
                    m_period = gap;
                    npulse++;
                end else begin
                    m_ref = gap;
                end
            end else begin
                m_ref = gap;
                if (d <= TOLERANCE) begin
                    if (gap != m_period) npulse++;
                    m_period = gap;
                end else begin
                    m_locked = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        sq_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        last_check = pulse_cnt;
        model_reset();
    endtask

    // Toggle sq_in, check once the edge has been absorbed, then finish the hold.
    task automatic run_vec(input vec_t v, input string tag);
        sq_in = ~sq_in;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1;
        chk($sformatf("%s_locked", tag), 32'(locked), v.locked);
        chk($sformatf("%s_silent", tag), 32'(silent), v.silent);
        chk($sformatf("%s_period", tag), 32'(period), v.period);
        chk($sformatf("%s_pulses", tag), pulse_cnt - last_check, v.pulses);
        last_check = pulse_cnt;
        repeat (v.n - SYNC_STAGES - 2) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl [25];
        vec_t v;
        int   n, tone, reps, np, prev_n;

        tbl[0]  = mk(1000, 0, 0,    0, 0);
        tbl[1]  = mk(1000, 0, 0,    0, 0);
        tbl[2]  = mk(1000, 1, 0, 1000, 1);
        tbl[3]  = mk(1000, 1, 0, 1000, 0);
        tbl[4]  = mk( 250, 1, 0, 1000, 0);
        tbl[5]  = mk( 250, 0, 0, 1000, 0);
        tbl[6]  = mk( 250, 1, 0,  250, 1);
        tbl[7]  = mk( 250, 1, 0,  250, 0);
        tbl[8]  = mk(1010, 1, 0,  250, 0);
        tbl[9]  = mk(1000, 0, 0,  250, 0);
        tbl[10] = mk(1010, 0, 0,  250, 0);
        tbl[11] = mk(1000, 0, 0,  250, 0);
        tbl[12] = mk(1003, 0, 0,  250, 0);
        tbl[13] = mk(1000, 1, 0, 1003, 1);
        tbl[14] = mk(1000, 1, 0, 1000, 1);
        tbl[15] = mk(1004, 1, 0, 1000, 0);
        tbl[16] = mk(1000, 1, 0, 1004, 1);
        tbl[17] = mk(1000, 1, 0, 1000, 1);
        tbl[18] = mk(1005, 1, 0, 1000, 0);
        tbl[19] = mk(1000, 0, 0, 1000, 0);
        tbl[20] = mk(5000, 0, 0, 1000, 0);
        tbl[21] = mk(5000, 0, 0, 1000, 0);
        tbl[22] = mk(5000, 1, 0, 5000, 1);
        tbl[23] = mk(5001, 1, 0, 5000, 0);
        tbl[24] = mk(1000, 0, 0,    0, 1);

        // reset values while reset is held
        rst   = 1'b1;
        sq_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", 32'(period), 0);
        chk("rst_valid", 32'(period_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_silent", 32'(silent), 1);
        rst = 1'b0;
        last_check = pulse_cnt;
        model_reset();

        // idle input stays silent
        repeat (10000) @(posedge clk);
        #1;
        chk("idle_silent", 32'(silent), 1);
        chk("idle_locked", 32'(locked), 0);
        chk("idle_period", 32'(period), 0);
        chk("idle_pulses", pulse_cnt - last_check, 0);
        last_check = pulse_cnt;

        for (int i = 0; i < 25; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // timeout from LOCKED lands exactly TIMEOUT cycles after the last edge
        do_reset();
        run_vec(mk(1000, 0, 0, 0, 0), "to1");
        run_vec(mk(1000, 0, 0, 0, 0), "to2");
        run_vec(mk(1000, 1, 0, 1000, 1), "to3");
        sq_in = ~sq_in;
        repeat (SYNC_STAGES + TIMEOUT) @(posedge clk);
        #1;
        chk("to_pre_locked", 32'(locked), 1);
        chk("to_pre_silent", 32'(silent), 0);
        @(posedge clk);
        #1;
        chk("to_silent", 32'(silent), 1);
        chk("to_locked", 32'(locked), 0);
        chk("to_period", 32'(period), 0);
        chk("to_valid", 32'(period_valid), 1);
        @(posedge clk);
        #1;
        chk("to_valid_drop", 32'(period_valid), 0);
        chk("to_pulses", pulse_cnt - last_check, 1);
        last_check = pulse_cnt;

        // asynchronous reset while locked, then relock
        do_reset();
        run_vec(mk(1000, 0, 0, 0, 0), "rl1");
        run_vec(mk(1000, 0, 0, 0, 0), "rl2");
        run_vec(mk(1000, 1, 0, 1000, 1), "rl3");
        sq_in = ~sq_in;
        repeat (500) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_period", 32'(period), 0);
        chk("arst_locked", 32'(locked), 0);
        chk("arst_silent", 32'(silent), 1);
        chk("arst_valid", 32'(period_valid), 0);
        repeat (3) @(posedge clk);
        sq_in = 1'b0;
        #1;
        rst = 1'b0;
        chk("arst_pulses", pulse_cnt - last_check, 0);
        last_check = pulse_cnt;
        model_reset();
        run_vec(mk(1000, 0, 0, 0, 0), "rr1");
        run_vec(mk(1000, 0, 0, 0, 0), "rr2");
        run_vec(mk(1000, 1, 0, 1000, 1), "rr3");

        // random tone bursts with jitter against the reference model
        do_reset();
        prev_n = 0;
        for (int b = 0; b < 14; b++) begin
            tone = tones[$urandom_range(0, 3)];
            reps = int'($urandom_range(3, 6));
            for (int r = 0; r < reps; r++) begin
                n = tone;
                if ($urandom_range(0, 3) == 0) n = tone + int'($urandom_range(0, 8)) - 4;
                model_edge(prev_n, np);
                v = mk(n, int'(m_locked), int'(m_silent), m_period, np);
                run_vec(v, $sformatf("rnd%0d_%0d", b, r));
                prev_n = n;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
- Receive-side counterpart of tone_generator: measures the half-period of an incoming square wave in clock cycles.
- Reports the half-period in the same units as tone_generator's tone_switch_period, so a measured value fed back to tone_generator reproduces the tone.
- Used in self-check benches and on-board loopback of the music streamer's audio output.
- Includes input synchronisation, a lock/qualify state machine and silence detection.

Parameters:
WIDTH, 24, width of the interval counter and the period output
SYNC_STAGES, 2, flops in the sq_in synchroniser (minimum 2)
TOLERANCE, 4, max difference in cycles between consecutive intervals to count as agreeing
TIMEOUT, 4000000, cycles without an edge before declaring silence (must be < 2^WIDTH)

Ports:
clk  input  1  system clock (125 MHz)
rst  input  1  asynchronous, active-high reset
sq_in  input  1  square wave under measurement (asynchronous to clk)
period  output  WIDTH  qualified half-period in clk cycles; 0 = silence
period_valid  output  1  one-cycle pulse when period is written
locked  output  1  high while in LOCKED
silent  output  1  high while in SILENT

Behaviour:
- Reset (async, active-high): period=0, period_valid=0, locked=0, silent=1, state=SILENT, cnt=0, cand=0, sync/prev flops=0. Asserting rst mid-measurement aborts immediately; no period_valid pulse is produced.
- Synchroniser: sq_in passes through SYNC_STAGES flops to give sq_s. prev holds sq_s delayed one cycle. edge = sq_s ^ prev, so both rising and falling edges are detected.
- Latency: a transition on sq_in produces edge SYNC_STAGES+1 cycles later. period, period_valid and locked update on the clock after edge.
- Interval counter cnt:
  - On edge: load 1.
  - Otherwise in SILENT: hold.
  - Otherwise in any other state: increment, saturating at TIMEOUT.
  - At an edge, cnt equals the number of cycles since the previous edge.
- States:
  - SILENT: on edge, go to FIRST_EDGE. No timeout is counted in this state.
  - FIRST_EDGE: on edge, cand=cnt, go to CANDIDATE.
  - CANDIDATE: on edge, if |cnt-cand| <= TOLERANCE then period=cnt, pulse period_valid, go to LOCKED. Otherwise cand=cnt and stay.
  - LOCKED: on edge, if |cnt-cand| <= TOLERANCE then period=cnt, cand=cnt, pulse period_valid only if the new period differs from the old. Otherwise cand=cnt, go to CANDIDATE; period holds and locked drops.
  - Any state except SILENT: if cnt==TIMEOUT and no edge, go to SILENT and set period=0, cand=0. period_valid pulses only if period was nonzero.
- Edge and timeout in the same cycle: the edge wins, and the interval is TIMEOUT. A sustained interval of TIMEOUT can therefore lock.
- Difference arithmetic: unsigned WIDTH+1-bit subtraction with absolute value. No wrap, because cnt saturates.
- Outputs are registered. locked and silent are decoded from registered state; locked and silent are never both 1.
- Steady duty-cycle asymmetry: if high and low phases differ by more than TOLERANCE, the meter never locks and stays alternating in CANDIDATE. tone_generator output is symmetric, so this does not arise in normal use.

Test Plan:
- Reset, idle sq_in=0 for 10000 cycles -> silent=1, period=0, no period_valid pulse.
- tone_generator with tone_switch_period=1000 drives sq_in -> period_valid pulses once with period=1000 (±1), locked=1. No further pulses while the tone is steady.
- Switch the tone to 250 mid-stream -> locked drops for at most one interval, then period=250, single period_valid pulse, locked=1.
- TIMEOUT=5000: locked at 1000, then hold sq_in constant -> exactly TIMEOUT cycles after the last edge: silent=1, locked=0, period=0, one period_valid pulse.
- Alternating intervals of 1000 and 1010 (TOLERANCE=4) -> never locks, period stays 0. Intervals of 1000 and 1003 -> locks with period=1003.
- Assert rst while locked at period=1000 -> period=0, locked=0, silent=1 in the same cycle (async), no period_valid. After release, relocks at 1000 within 3 edges.
